// File: rtl/ti_pkg.sv
// rtl/ti_pkg.sv - shared constants for threshold-implementation stages
package ti_pkg;
  localparam int NSHARES = 3;
  localparam int TI_W    = 8;
endpackage

// File: rtl/ti_refresh3.sv
// rtl/ti_refresh3.sv - combinational 3-share refresh using 2*W fresh random bits
module ti_refresh3 import ti_pkg::*; #(
  parameter int W = TI_W
) (
  input  logic [W-1:0]   z1_i,
  input  logic [W-1:0]   z2_i,
  input  logic [W-1:0]   z3_i,
  input  logic [2*W-1:0] rand_i,
  output logic [W-1:0]   z1_o,
  output logic [W-1:0]   z2_o,
  output logic [W-1:0]   z3_o
);
  logic [W-1:0] r0, r1;

  assign r0 = rand_i[W-1:0];
  assign r1 = rand_i[2*W-1:W];

  // The three masks XOR to zero, so the unmasked value is preserved.
  assign z1_o = z1_i ^ r0;
  assign z2_o = z2_i ^ r1;
  assign z3_o = z3_i ^ r0 ^ r1;
endmodule

// File: rtl/ti_toffoli.sv
// rtl/ti_toffoli.sv - combinational 3-share threshold-implementation Toffoli core
module ti_toffoli import ti_pkg::*; #(
  parameter int W = TI_W
) (
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  input  logic [W-1:0] x3_i,
  input  logic [W-1:0] y1_i,
  input  logic [W-1:0] y2_i,
  input  logic [W-1:0] y3_i,
  input  logic [W-1:0] z1_i,
  input  logic [W-1:0] z2_i,
  input  logic [W-1:0] z3_i,
  output logic [W-1:0] c1_o,
  output logic [W-1:0] c2_o,
  output logic [W-1:0] c3_o
);
  // Each output share omits one input share index (non-completeness).
  assign c1_o = (x2_i & y2_i) ^ (x2_i & y3_i) ^ (x3_i & y2_i) ^ z2_i;
  assign c2_o = (x3_i & y3_i) ^ (x3_i & y1_i) ^ (x1_i & y3_i) ^ z3_i;
  assign c3_o = (x1_i & y1_i) ^ (x1_i & y2_i) ^ (x2_i & y1_i) ^ z1_i;
endmodule

// File: rtl/ti_toffoli_pipe.sv
// rtl/ti_toffoli_pipe.sv - registered valid/ready wrapper around the TI Toffoli core
module ti_toffoli_pipe import ti_pkg::*; #(
  parameter int W     = TI_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [W-1:0]     X1_i,
  input  logic [W-1:0]     X2_i,
  input  logic [W-1:0]     X3_i,
  input  logic [W-1:0]     Y1_i,
  input  logic [W-1:0]     Y2_i,
  input  logic [W-1:0]     Y3_i,
  input  logic [W-1:0]     Z1_i,
  input  logic [W-1:0]     Z2_i,
  input  logic [W-1:0]     Z3_i,
  input  logic [2*W-1:0]   rand_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W-1:0]     C1_o,
  output logic [W-1:0]     C2_o,
  output logic [W-1:0]     C3_o,
  output logic [CNT_W-1:0] done_cnt_o
);
  logic             va_q, va_d, vb_q, vb_d;
  logic             adv_a, adv_b, in_hs, out_hs;
  logic [W-1:0]     xa1_q, xa2_q, xa3_q, ya1_q, ya2_q, ya3_q, za1_q, za2_q, za3_q;
  logic [W-1:0]     zr1, zr2, zr3, c1_core, c2_core, c3_core;
  logic [W-1:0]     cb1_q, cb2_q, cb3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign adv_b   = !vb_q || ready_i;
  assign adv_a   = !va_q || adv_b;
  assign ready_o = adv_a;
  assign in_hs   = valid_i && adv_a;
  assign out_hs  = vb_q && ready_i;

  ti_refresh3 #(.W(W)) u_refresh (
    .z1_i(Z1_i), .z2_i(Z2_i), .z3_i(Z3_i), .rand_i(rand_i),
    .z1_o(zr1),  .z2_o(zr2),  .z3_o(zr3)
  );

  // Core sees only stage A registers, so its glitches stay between register boundaries.
  ti_toffoli #(.W(W)) u_core (
    .x1_i(xa1_q), .x2_i(xa2_q), .x3_i(xa3_q),
    .y1_i(ya1_q), .y2_i(ya2_q), .y3_i(ya3_q),
    .z1_i(za1_q), .z2_i(za2_q), .z3_i(za3_q),
    .c1_o(c1_core), .c2_o(c2_core), .c3_o(c3_core)
  );

  always_comb begin
    va_d  = adv_a ? in_hs : va_q;
    vb_d  = adv_b ? va_q : vb_q;
    cnt_d = out_hs ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      va_q  <= 1'b0;
      vb_q  <= 1'b0;
      cnt_q <= '0;
      xa1_q <= '0; xa2_q <= '0; xa3_q <= '0;
      ya1_q <= '0; ya2_q <= '0; ya3_q <= '0;
      za1_q <= '0; za2_q <= '0; za3_q <= '0;
      cb1_q <= '0; cb2_q <= '0; cb3_q <= '0;
    end else begin
      va_q  <= va_d;
      vb_q  <= vb_d;
      cnt_q <= cnt_d;
      if (in_hs) begin
        xa1_q <= X1_i; xa2_q <= X2_i; xa3_q <= X3_i;
        ya1_q <= Y1_i; ya2_q <= Y2_i; ya3_q <= Y3_i;
        za1_q <= zr1;  za2_q <= zr2;  za3_q <= zr3;
      end
      if (adv_b) begin
        cb1_q <= c1_core;
        cb2_q <= c2_core;
        cb3_q <= c3_core;
      end
    end
  end

  assign valid_o    = vb_q;
  assign C1_o       = cb1_q;
  assign C2_o       = cb2_q;
  assign C3_o       = cb3_q;
  assign done_cnt_o = cnt_q;
endmodule

// File: tb/tb_ti_toffoli_pipe.sv
// tb/tb_ti_toffoli_pipe.sv - self-checking bench for ti_toffoli_pipe
module tb_ti_toffoli_pipe;
  localparam int W = 8;

  typedef struct {
    logic [7:0]  x1, x2, x3, y1, y2, y3, z1, z2, z3;
    logic [15:0] rnd;
    logic [7:0]  exp;
    bit          shr;
    logic [7:0]  e1, e2, e3;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i, valid_i, ready_i, ready_o, valid_o;
  logic [W-1:0] x1, x2, x3, y1, y2, y3, z1, z2, z3;
  logic [2*W-1:0] rnd;
  logic [W-1:0] c1, c2, c3;
  logic [15:0] cnt;
  logic ready4, valid4;
  logic [W-1:0] c41, c42, c43;
  logic [3:0] cnt4;

  int checks = 0, errors = 0, cyc = 0, model_cnt = 0;
  logic [7:0] q[$];
  bit mon_en = 0, stall_prev = 0;
  logic [7:0] h1, h2, h3;
  vec_t tbl[6];

  ti_toffoli_pipe #(.W(W), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .X1_i(x1), .X2_i(x2), .X3_i(x3), .Y1_i(y1), .Y2_i(y2), .Y3_i(y3),
    .Z1_i(z1), .Z2_i(z2), .Z3_i(z3), .rand_i(rnd),
    .valid_o(valid_o), .ready_i(ready_i),
    .C1_o(c1), .C2_o(c2), .C3_o(c3), .done_cnt_o(cnt)
  );

  ti_toffoli_pipe #(.W(W), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready4),
    .X1_i(x1), .X2_i(x2), .X3_i(x3), .Y1_i(y1), .Y2_i(y2), .Y3_i(y3),
    .Z1_i(z1), .Z2_i(z2), .Z3_i(z3), .rand_i(rnd),
    .valid_o(valid4), .ready_i(ready_i),
    .C1_o(c41), .C2_o(c42), .C3_o(c43), .done_cnt_o(cnt4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of unmasked results plus a handshake counter.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("done_cnt", {16'h0, cnt}, model_cnt & 32'hFFFF);
      chk("done_cnt4", {28'h0, cnt4}, model_cnt & 32'hF);
      chk("ready_o", {31'h0, ready_o}, {31'h0, (q.size() < 2) || ready_i});
      if (stall_prev) begin
        chk("hold_valid", {31'h0, valid_o}, 32'h1);
        chk("hold_c", {8'h0, c1, c2, c3}, {8'h0, h1, h2, h3});
      end
      stall_prev = valid_o && !ready_i;
      h1 = c1; h2 = c2; h3 = c3;
      if (valid_o && ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stale_out: output handshake with no outstanding transaction (C=%h)", c1 ^ c2 ^ c3);
        end else begin
          logic [7:0] e;
          e = q.pop_front();
          if ((c1 ^ c2 ^ c3) !== e) begin
            errors++;
            $display("FAIL unmasked: got %h, expected %h", c1 ^ c2 ^ c3, e);
          end
        end
        model_cnt++;
      end
      if (valid_i && ready_o)
        q.push_back(((x1 ^ x2 ^ x3) & (y1 ^ y2 ^ y3)) ^ (z1 ^ z2 ^ z3));
    end
  end

  task automatic apply(input vec_t v);
    x1 = v.x1; x2 = v.x2; x3 = v.x3;
    y1 = v.y1; y2 = v.y2; y3 = v.y3;
    z1 = v.z1; z2 = v.z2; z3 = v.z3;
    rnd = v.rnd;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.x1 = 8'($urandom); v.x2 = 8'($urandom); v.x3 = 8'($urandom);
    v.y1 = 8'($urandom); v.y2 = 8'($urandom); v.y3 = 8'($urandom);
    v.z1 = 8'($urandom); v.z2 = 8'($urandom); v.z3 = 8'($urandom);
    v.rnd = 16'($urandom);
    v.exp = 8'h00; v.shr = 0; v.e1 = 8'h00; v.e2 = 8'h00; v.e3 = 8'h00;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, output bit ok);
    apply(v);
    valid_i = 1'b1;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (ready_o) ok = 1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    chk("accept_in_time", {31'h0, ok}, 32'h1);
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit ok;
    int t0, c0;
    vec_t v;

    tbl[0] = '{8'h11,8'h22,8'h96, 8'h01,8'h02,8'h3F, 8'h0F,8'h00,8'h00, 16'h0000, 8'h2B, 1, 8'h22,8'h07,8'h0E};
    tbl[1] = '{8'h11,8'h22,8'h96, 8'h01,8'h02,8'h3F, 8'h0F,8'h00,8'h00, 16'hC35A, 8'h2B, 1, 8'hE1,8'h9E,8'h54};
    tbl[2] = '{8'hFF,8'h00,8'h00, 8'h0F,8'hF0,8'h00, 8'h12,8'h34,8'h56, 16'h1234, 8'h8F, 0, 8'h00,8'h00,8'h00};
    tbl[3] = '{8'h00,8'h00,8'h00, 8'hAB,8'hCD,8'hEF, 8'h01,8'h02,8'h04, 16'hBEEF, 8'h07, 0, 8'h00,8'h00,8'h00};
    tbl[4] = '{8'h30,8'hC0,8'h00, 8'h0F,8'h00,8'h00, 8'hAA,8'h00,8'h00, 16'hFFFF, 8'hAA, 0, 8'h00,8'h00,8'h00};
    tbl[5] = '{8'h80,8'h80,8'h80, 8'h81,8'h00,8'h01, 8'h01,8'h01,8'h00, 16'h8001, 8'h80, 0, 8'h00,8'h00,8'h00};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    apply(tbl[0]);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", {31'h0, valid_o}, 32'h0);
    chk("rst_c", {8'h0, c1, c2, c3}, 32'h0);
    chk("rst_cnt", {16'h0, cnt}, 32'h0);
    chk("rst_ready_o", {31'h0, ready_o}, 32'h1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    mon_en = 1;

    // Table vectors: latency, unmasked result, exact shares where fixed.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i], ok);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid_early", i), {31'h0, valid_o}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'h0, valid_o}, 32'h1);
      chk($sformatf("tbl%0d_xor", i), {24'h0, c1 ^ c2 ^ c3}, {24'h0, tbl[i].exp});
      if (tbl[i].shr)
        chk($sformatf("tbl%0d_shares", i), {8'h0, c1, c2, c3}, {8'h0, tbl[i].e1, tbl[i].e2, tbl[i].e3});
      @(posedge clk); #1;
    end
    drain(2);
    chk("tbl_done", {16'h0, cnt}, 32'd6);

    // Backpressure: two accepts then stall, then release.
    c0 = model_cnt;
    ready_i = 1'b0;
    send(rand_vec(), ok);
    send(rand_vec(), ok);
    v = rand_vec();
    apply(v);
    valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready_low", {31'h0, ready_o}, 32'h0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    send(v, ok);
    send(rand_vec(), ok);
    drain(3);
    chk("bp_done4", model_cnt - c0, 32'd4);
    chk("bp_empty", q.size(), 32'd0);

    // Streaming: one accept per cycle.
    c0 = model_cnt;
    t0 = cyc;
    for (int i = 0; i < 256; i++) send(rand_vec(), ok);
    chk("stream_cycles", cyc - t0, 32'd256);
    drain(2);
    chk("stream_done", model_cnt - c0, 32'd256);
    chk("stream_empty", q.size(), 32'd0);

    // Reset with both stages full.
    ready_i = 1'b0;
    send(rand_vec(), ok);
    send(rand_vec(), ok);
    @(negedge clk);
    chk("pre_rst_full", {31'h0, ready_o}, 32'h0);
    @(posedge clk); #1;
    mon_en = 0; stall_prev = 0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, valid_o}, 32'h0);
    chk("mid_rst_c", {8'h0, c1, c2, c3}, 32'h0);
    chk("mid_rst_cnt", {16'h0, cnt}, 32'h0);
    chk("mid_rst_ready", {31'h0, ready_o}, 32'h1);
    @(posedge clk); #1;
    mon_en = 1;
    ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_valid", {31'h0, valid_o}, 32'h0);
      @(posedge clk); #1;
    end

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) send(rand_vec(), ok);
    drain(2);
    chk("wrap_cnt4", {28'h0, cnt4}, 32'd1);
    chk("wrap_cnt16", {16'h0, cnt}, 32'd17);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
